// File: rtl/bram_port_arbiter_if.sv
// Request/grant bundle between the fetch reader, the writeback writer and the BRAM port arbiter.
// Pure wiring, no latency; the arbiter holds off a requester by leaving its grant low.
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_gnt_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_gnt_o;

    modport slave (
        input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        output rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o
    );

    modport master (
        output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
        input  rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between a reader and a writer in bursts of up to BURST_LEN beats.
// Grant is combinational, BRAM drive one cycle after grant, rd_valid RD_LAT cycles later; losers wait on gnt low.
module bram_port_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_port_arbiter_if.slave  req,
    output logic                ena_o,
    output logic                wea_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   d2mem_o,
    input  logic [DATA_W-1:0]   mem2d_i,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [7:0] BURST = 8'(BURST_LEN);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                last_wr_q, last_wr_d;
    logic                ena_q, ena_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   d2mem_q, d2mem_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;

    logic arb;
    logic rd_win;
    logic wr_win;
    logic rd_gnt;
    logic wr_gnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Next state: re-arbitrate when idle, when the owner lets go, or when its burst is used up
    always_comb begin
        arb = !(state_q == S_RD || state_q == S_WR)
            || (state_q == S_RD && !req.rd_req_i)
            || (state_q == S_WR && !req.wr_req_i)
            || (cnt_q == BURST);
        rd_win = 1'b0;
        wr_win = 1'b0;
        if (arb) begin
            if (req.rd_req_i && req.wr_req_i) begin
                rd_win = last_wr_q;
                wr_win = !last_wr_q;
            end else begin
                rd_win = req.rd_req_i;
                wr_win = req.wr_req_i;
            end
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        if (arb) begin
            if (rd_win) begin
                state_d   = S_RD;
                cnt_d     = 8'd1;
                last_wr_d = 1'b0;
            end else if (wr_win) begin
                state_d   = S_WR;
                cnt_d     = 8'd1;
                last_wr_d = 1'b1;
            end else begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs: grants are held low for the whole time reset is asserted
    always_comb begin
        rd_gnt = rst_n && (arb ? rd_win : (state_q == S_RD));
        wr_gnt = rst_n && (arb ? wr_win : (state_q == S_WR));

        ena_d   = rd_gnt || wr_gnt;
        wea_d   = wr_gnt;
        addr_d  = addr_q;
        d2mem_d = d2mem_q;
        if (wr_gnt) begin
            addr_d  = req.wr_addr_i;
            d2mem_d = req.wr_data_i;
        end else if (rd_gnt) begin
            addr_d = req.rd_addr_i;
        end

        vld_d    = vld_q << 1;
        vld_d[0] = ena_q && !wea_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            addr_q  <= '0;
            d2mem_q <= '0;
            vld_q   <= '0;
        end else begin
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addr_q  <= addr_d;
            d2mem_q <= d2mem_d;
            vld_q   <= vld_d;
        end
    end

    assign req.rd_gnt_o   = rd_gnt;
    assign req.wr_gnt_o   = wr_gnt;
    assign req.rd_data_o  = mem2d_i;
    assign req.rd_valid_o = vld_q[RD_LAT-1];

    assign ena_o   = ena_q;
    assign wea_o   = wea_q;
    assign addr_o  = addr_q;
    assign d2mem_o = d2mem_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural grant/BRAM model checked every cycle, plus directed scenarios.
// A second instance with single-beat bursts and longer read latency is checked for strict alternation.
module tb_bram_port_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int BL = 16;
    localparam int RL = 1;

    logic clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    logic          ena_o, wea_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] d2mem_o;
    logic [DW-1:0] mem2d;
    logic [1:0]    state_o;

    logic          ena2, wea2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] d2m2;
    logic [1:0]    state2;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus),
        .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .d2mem_o(d2mem_o),
        .mem2d_i(mem2d), .state_o(state_o)
    );

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(1), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(bus2),
        .ena_o(ena2), .wea_o(wea2), .addr_o(addr2), .d2mem_o(d2m2),
        .mem2d_i(8'h3C), .state_o(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pre(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // BRAM behavioural model driven by the DUT port
    logic [7:0] bmem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (ena_o) begin
            if (wea_o) bmem[addr_o] = d2mem_o;
            else mem2d <= bmem.exists(addr_o) ? bmem[addr_o] : pre(addr_o);
        end
    end

    // Reference model: who must own the port and what the BRAM must see
    logic [7:0] refmem [logic [AW-1:0]];
    int         m_owner, m_run, m_last;
    logic       exp_ena, exp_wea;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_d2m;
    int         dueq [$];
    logic [7:0] datq [$];

    always @(negedge clk) begin : model
        int win;
        bit cont;
        bit ev;
        cyc++;
        if (!rst_n) begin
            m_owner = 0; m_run = 0; m_last = 2;
            exp_ena = 1'b0; exp_wea = 1'b0; exp_addr = '0; exp_d2m = '0;
            dueq.delete(); datq.delete();
            chk("rst_rd_gnt", 32'(bus.rd_gnt_o), 32'd0);
            chk("rst_wr_gnt", 32'(bus.wr_gnt_o), 32'd0);
            chk("rst_state", 32'(state_o), 32'd0);
            chk("rst_ena", 32'(ena_o), 32'd0);
            chk("rst_wea", 32'(wea_o), 32'd0);
            chk("rst_addr", 32'(addr_o), 32'd0);
            chk("rst_d2mem", 32'(d2mem_o), 32'd0);
            chk("rst_valid", 32'(bus.rd_valid_o), 32'd0);
        end else begin
            ev = (dueq.size() > 0) && (dueq[0] == cyc);
            cont = ((m_owner == 1 && bus.rd_req_i) || (m_owner == 2 && bus.wr_req_i)) && (m_run < BL);
            if (cont) win = m_owner;
            else if (bus.rd_req_i && bus.wr_req_i) win = (m_last == 1) ? 2 : 1;
            else if (bus.rd_req_i) win = 1;
            else if (bus.wr_req_i) win = 2;
            else win = 0;

            chk("rd_gnt", 32'(bus.rd_gnt_o), 32'(win == 1));
            chk("wr_gnt", 32'(bus.wr_gnt_o), 32'(win == 2));
            chk("state", 32'(state_o), 32'(m_owner));
            chk("ena", 32'(ena_o), 32'(exp_ena));
            chk("wea", 32'(wea_o), 32'(exp_wea));
            chk("addr", 32'(addr_o), 32'(exp_addr));
            chk("d2mem", 32'(d2mem_o), 32'(exp_d2m));
            chk("rd_valid", 32'(bus.rd_valid_o), 32'(ev));
            if (ev) begin
                chk("rd_data", 32'(bus.rd_data_o), 32'(datq[0]));
                void'(dueq.pop_front());
                void'(datq.pop_front());
            end

            exp_ena = (win != 0);
            exp_wea = (win == 2);
            if (win == 1) begin
                exp_addr = bus.rd_addr_i;
                dueq.push_back(cyc + 1 + RL);
                datq.push_back(refmem.exists(bus.rd_addr_i) ? refmem[bus.rd_addr_i] : pre(bus.rd_addr_i));
            end else if (win == 2) begin
                exp_addr = bus.wr_addr_i;
                exp_d2m  = bus.wr_data_i;
                refmem[bus.wr_addr_i] = bus.wr_data_i;
            end
            m_run   = cont ? m_run + 1 : ((win != 0) ? 1 : 0);
            m_owner = win;
            if (win != 0) m_last = win;
        end
    end

    // Single-beat burst instance: both always requesting, grants must alternate RD,WR,...
    bit       e2_rd;
    bit [2:0] h2;
    always @(negedge clk) begin
        if (!rst_n) begin
            e2_rd = 1'b1;
            h2 = 3'b000;
            chk("b1_rst_rd_gnt", 32'(bus2.rd_gnt_o), 32'd0);
            chk("b1_rst_valid", 32'(bus2.rd_valid_o), 32'd0);
        end else begin
            chk("b1_rd_gnt", 32'(bus2.rd_gnt_o), 32'(e2_rd));
            chk("b1_wr_gnt", 32'(bus2.wr_gnt_o), 32'(!e2_rd));
            chk("b1_rd_valid", 32'(bus2.rd_valid_o), 32'(h2[2]));
            h2 = {h2[1:0], e2_rd};
            e2_rd = !e2_rd;
        end
    end

    initial begin
        bit ga_r [40];
        bit ga_w [40];
        bit got;
        int n;
        rst_n = 1'b0;
        bus.rd_req_i = 1'b1; bus.rd_addr_i = 19'h00040;
        bus.wr_req_i = 1'b1; bus.wr_addr_i = 19'h00080; bus.wr_data_i = 8'h33;
        bus2.rd_req_i = 1'b1; bus2.rd_addr_i = '0;
        bus2.wr_req_i = 1'b1; bus2.wr_addr_i = '0; bus2.wr_data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both requesting from reset: 16 RD, 16 WR, then RD again, first grant right away
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ga_r[i] = bus.rd_gnt_o;
            ga_w[i] = bus.wr_gnt_o;
        end
        for (int i = 0; i < 40; i++) begin
            chk("burst_rd", 32'(ga_r[i]), 32'(((i / 16) % 2) == 0));
            chk("burst_wr", 32'(ga_w[i]), 32'(((i / 16) % 2) == 1));
        end

        // Reader owner drops request after 5 beats while writer waits
        @(posedge clk); #1 bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.rd_req_i = 1'b1; bus.rd_addr_i = 19'h00100;
        @(negedge clk); chk("drop_gnt1", 32'(bus.rd_gnt_o), 32'd1);
        @(posedge clk); #1 bus.wr_req_i = 1'b1; bus.wr_addr_i = 19'h00200; bus.wr_data_i = 8'h11;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk); chk("drop_hold_rd", 32'(bus.rd_gnt_o), 32'd1);
        end
        @(posedge clk); #1 bus.rd_req_i = 1'b0;
        @(negedge clk);
        chk("drop_wr_gnt", 32'(bus.wr_gnt_o), 32'd1);
        chk("drop_rd_gnt", 32'(bus.rd_gnt_o), 32'd0);
        @(negedge clk); chk("drop_state", 32'(state_o), 32'd2);

        // Write 0xA5 to 0x12345, then read it back
        @(posedge clk); #1 bus.wr_addr_i = 19'h12345; bus.wr_data_i = 8'hA5;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); if (bus.wr_gnt_o) got = 1'b1;
        end
        chk("wb_wr_gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1 bus.wr_req_i = 1'b0; bus.rd_req_i = 1'b1; bus.rd_addr_i = 19'h12345;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); if (bus.rd_gnt_o) got = 1'b1;
        end
        chk("wb_rd_gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #1 bus.rd_req_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.rd_valid_o) begin
                got = 1'b1;
                chk("wb_rd_data", 32'(bus.rd_data_o), 32'hA5);
            end
        end
        chk("wb_rd_valid_seen", 32'(got), 32'd1);

        // Reset with one read in flight
        @(posedge clk); #1 bus.rd_req_i = 1'b1; bus.rd_addr_i = 19'h00777;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); if (bus.rd_gnt_o) got = 1'b1;
        end
        chk("inflight_gnt_seen", 32'(got), 32'd1);
        @(posedge clk); #3 rst_n = 1'b0; bus.wr_req_i = 1'b1;
        #1;
        chk("async_rst_ena", 32'(ena_o), 32'd0);
        chk("async_rst_addr", 32'(addr_o), 32'd0);
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_rd_gnt", 32'(bus.rd_gnt_o), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tie_rd", 32'(bus.rd_gnt_o), 32'd1);
        chk("post_rst_valid0", 32'(bus.rd_valid_o), 32'd0);
        @(negedge clk); chk("post_rst_valid1", 32'(bus.rd_valid_o), 32'd0);
        @(negedge clk); chk("post_rst_valid2", 32'(bus.rd_valid_o), 32'd1);
        @(posedge clk); #1 bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0;

        // Streaming reads only, address 0x10 upward
        bus.rd_req_i = 1'b1; bus.rd_addr_i = 19'h00010;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); got = bus.rd_gnt_o;
            if (got) n++;
            @(posedge clk); #1 if (got) bus.rd_addr_i = bus.rd_addr_i + 19'd1;
        end
        chk("stream_rd_gnts", 32'(n), 32'd30);
        bus.rd_req_i = 1'b0;

        // Random traffic on a small address window so writes and reads collide
        for (int i = 0; i < 2500; i++) begin
            bit gr, gw;
            @(negedge clk); gr = bus.rd_gnt_o; gw = bus.wr_gnt_o;
            @(posedge clk); #1;
            if (!bus.rd_req_i || gr) begin
                bus.rd_req_i  = ($urandom_range(0, 3) != 0);
                bus.rd_addr_i = 19'h12340 + 19'($urandom_range(0, 15));
            end
            if (!bus.wr_req_i || gw) begin
                bus.wr_req_i  = ($urandom_range(0, 2) == 0);
                bus.wr_addr_i = 19'h12340 + 19'($urandom_range(0, 15));
                bus.wr_data_i = 8'($urandom);
            end
        end

        bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, BRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, BRAM data width.
REQ-003 SHALL have parameter BURST_LEN, default 16, max consecutive grants to one owner; legal range 1..255.
REQ-004 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles; legal range 1..3.
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port rd_req_i, input, 1, read requester (fetch side) request.
REQ-008 SHALL have port rd_addr_i, input, ADDR_W, read address.
REQ-009 SHALL have port rd_gnt_o, output, 1, read accepted this cycle.
REQ-010 SHALL have port rd_data_o, output, DATA_W, read data.
REQ-011 SHALL have port rd_valid_o, output, 1, rd_data_o valid.
REQ-012 SHALL have port wr_req_i, input, 1, write requester (result writeback) request.
REQ-013 SHALL have port wr_addr_i, input, ADDR_W, write address.
REQ-014 SHALL have port wr_data_i, input, DATA_W, write data.
REQ-015 SHALL have port wr_gnt_o, output, 1, write accepted this cycle.
REQ-016 SHALL have ports ena_o, wea_o (output, 1), addr_o (output, ADDR_W), d2mem_o (output, DATA_W): BRAM port A drive.
REQ-017 SHALL have port mem2d_i, input, DATA_W, BRAM douta.
REQ-018 SHALL have port state_o, output, 2, debug FSM state (0 IDLE, 1 RD, 2 WR).

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, plus beat counter cnt (0..BURST_LEN); owner = RD/WR state.
REQ-020 SHALL arbitrate in a cycle when state==IDLE, owner's request low, or cnt==BURST_LEN.
REQ-021 On arbitration: one request -> that requester wins; both -> requester other than last owner wins (last owner reset value = WR, so RD wins first tie); none -> no grant, state<=IDLE, cnt<=0.
REQ-022 Winner SHALL be granted in the arbitration cycle (combinational gnt), state<=winner, cnt<=1.
REQ-023 Non-arbitration cycle: owner granted, cnt<=cnt+1; other requester not granted.
REQ-024 rd_gnt_o and wr_gnt_o SHALL never be high together; gnt only asserted while matching req high.
REQ-025 Requester SHALL hold addr/data stable while req high and gnt low; each gnt cycle = one transfer.
REQ-026 Max wait for a continuously requesting loser SHALL be BURST_LEN cycles.
REQ-027 Cycle after a grant, ena_o=1, addr_o=granted address, wea_o=1 and d2mem_o=wr_data_i for write, wea_o=0 for read; no grant -> ena_o=0, wea_o=0, addr_o/d2mem_o hold.
REQ-028 rd_valid_o SHALL pulse exactly RD_LAT cycles after each ena_o&&!wea_o cycle (grant-to-valid = RD_LAT+1 cycles); rd_data_o = mem2d_i unregistered.
REQ-029 Back-to-back read grants SHALL yield back-to-back rd_valid_o pulses in order; no reads dropped across owner switches.
REQ-030 Switching RD->WR or WR->RD SHALL insert no idle cycle when the new owner is requesting.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, cnt=0, last owner=WR, ena_o=0, wea_o=0, addr_o=0, d2mem_o=0, rd_valid pipeline cleared, gnt outputs 0.
REQ-032 Reads in flight at reset SHALL be discarded (no rd_valid_o after reset release).
REQ-033 First grant possible in first clock edge cycle after rst_n deasserts.

Verification
REQ-034 Only rd_req_i high, addr 0x00010 incrementing, RD_LAT=1 -> rd_gnt_o every cycle, ena_o=1/wea_o=0 one cycle later, rd_valid_o two cycles after each grant, data matches BRAM preload.
REQ-035 rd_req_i and wr_req_i both held high from reset, BURST_LEN=16 -> RD granted 16 cycles, then WR 16, alternating, no gap, never both grants.
REQ-036 RD owner drops rd_req_i at cnt=5 while wr_req_i high -> wr_gnt_o same cycle, cnt=1, state_o=2.
REQ-037 Write 0xA5 to addr 0x12345 then read same addr -> rd_data_o=0xA5 with rd_valid_o.
REQ-038 rst_n pulsed low with 1 read in flight -> outputs at reset values immediately, no rd_valid_o afterward, next tie goes to RD.
REQ-039 BURST_LEN=1, both requesting -> grants alternate RD,WR every cycle.
